// File: rtl/distfix_mul_pkg.sv
`default_nettype none
// distfix_mul_pkg: shared widths and default parameters for the arbitrated multiplier (rev 1.0)
package distfix_mul_pkg;
   localparam int OPW            = 17;
   localparam int PW             = 34;
   localparam int N_REQ_DEF      = 4;
   localparam int NUM_STAGE_DEF  = 3;
   localparam int FIFO_DEPTH_DEF = 4;

   // Index width that stays legal when a count collapses to 1.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage
`default_nettype wire

// File: rtl/distfix_mul_pipe.sv
`default_nettype none
// distfix_mul_pipe: signed 17x17 multiplier pipeline carrying valid and id (rev 1.0)
module distfix_mul_pipe
   import distfix_mul_pkg::*;
#(
   parameter int NUM_STAGE = NUM_STAGE_DEF,
   parameter int IDW       = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [IDW-1:0]        in_id,
   input  logic signed [OPW-1:0] in_a,
   input  logic signed [OPW-1:0] in_b,
   output logic                  out_valid,
   output logic [IDW-1:0]        out_id,
   output logic signed [PW-1:0]  out_p
);
   // The parent's result-FIFO write is the final stage, so only NUM_STAGE-1 registers live here.
   localparam int NREG = NUM_STAGE - 1;

   logic signed [PW-1:0] a_ext;
   logic signed [PW-1:0] b_ext;
   logic signed [PW-1:0] prod;

   assign a_ext = in_a;
   assign b_ext = in_b;
   assign prod  = a_ext * b_ext;

   generate
      if (NREG == 0) begin : g_bypass
         assign out_valid = in_valid;
         assign out_id    = in_id;
         assign out_p     = prod;
      end else begin : g_regs
         logic                 vld  [NREG];
         logic [IDW-1:0]       id_q [NREG];
         logic signed [PW-1:0] p_q  [NREG];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int s = 0; s < NREG; s++) vld[s] <= 1'b0;
            end else begin
               vld[0] <= in_valid;
               for (int s = 1; s < NREG; s++) vld[s] <= vld[s-1];
            end
         end

         always_ff @(posedge clk) begin
            id_q[0] <= in_id;
            p_q[0]  <= prod;
            for (int s = 1; s < NREG; s++) begin
               id_q[s] <= id_q[s-1];
               p_q[s]  <= p_q[s-1];
            end
         end

         assign out_valid = vld[NREG-1];
         assign out_id    = id_q[NREG-1];
         assign out_p     = p_q[NREG-1];
      end
   endgenerate
endmodule
`default_nettype wire

// File: rtl/distfix_mul_arb.sv
`default_nettype none
// distfix_mul_arb: round-robin requesters sharing one pipelined multiplier, credit-gated result FIFO (rev 1.0)
module distfix_mul_arb
   import distfix_mul_pkg::*;
#(
   parameter  int N_REQ      = N_REQ_DEF,
   parameter  int NUM_STAGE  = NUM_STAGE_DEF,
   parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int IDW        = idx_w(N_REQ)
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [OPW*N_REQ-1:0]   req_a,
   input  logic [OPW*N_REQ-1:0]   req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic signed [PW-1:0]   rsp_p,
   output logic [IDW-1:0]         rsp_id
);
   localparam int              CW       = $clog2(FIFO_DEPTH + 1);
   localparam int              PTRW     = idx_w(FIFO_DEPTH);
   localparam logic [IDW-1:0]  LAST_IDX = IDW'(N_REQ - 1);
   localparam logic [PTRW-1:0] PTR_MAX  = PTRW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0]   CREDITS  = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [IDW-1:0]       id;
      logic signed [PW-1:0] p;
   } rsp_t;

   logic signed [OPW-1:0] a_arr [N_REQ];
   logic signed [OPW-1:0] b_arr [N_REQ];

   generate
      for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
         assign a_arr[i] = req_a[OPW*i +: OPW];
         assign b_arr[i] = req_b[OPW*i +: OPW];
      end
   endgenerate

   logic [IDW-1:0]  last_grant;
   logic [IDW-1:0]  grant_id;
   logic [IDW-1:0]  cand;
   logic            grant_found;
   logic            can_issue;
   logic            xfer;
   logic            pop;
   logic            push;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   count;
   logic [PTRW-1:0] wr_ptr;
   logic [PTRW-1:0] rd_ptr;
   rsp_t            mem [FIFO_DEPTH];

   logic                 pipe_valid;
   logic [IDW-1:0]       pipe_id;
   logic signed [PW-1:0] pipe_p;

   // Search order starts just after the previous winner.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      cand        = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDW'((int'(last_grant) + k) % N_REQ);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_id    = cand;
         end
      end
   end

   // Credits cover both in-flight ops and queued results, so the FIFO can never overflow.
   assign can_issue = ap_rst_n && (outstanding < CREDITS);
   assign xfer      = can_issue && grant_found;

   always_comb begin
      req_ready = '0;
      if (xfer) req_ready[grant_id] = 1'b1;
   end

   assign rsp_valid = ap_rst_n && (count != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign push      = pipe_valid;
   assign rsp_p     = mem[rd_ptr].p;
   assign rsp_id    = mem[rd_ptr].id;

   distfix_mul_pipe #(
      .NUM_STAGE (NUM_STAGE),
      .IDW       (IDW)
   ) u_pipe (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .in_valid  (xfer),
      .in_id     (grant_id),
      .in_a      (a_arr[grant_id]),
      .in_b      (b_arr[grant_id]),
      .out_valid (pipe_valid),
      .out_id    (pipe_id),
      .out_p     (pipe_p)
   );

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         last_grant  <= LAST_IDX;
         outstanding <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         if (xfer) last_grant <= grant_id;
         outstanding <= outstanding + CW'(xfer) - CW'(pop);
         count       <= count + CW'(push) - CW'(pop);
         if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (push) mem[wr_ptr] <= '{id: pipe_id, p: pipe_p};
   end
endmodule
`default_nettype wire

// File: tb/tb_distfix_mul_arb.sv
`default_nettype none
// tb_distfix_mul_arb: directed table vectors plus hand-written arbitration/backpressure/reset sequences (rev 1.0)
module tb_distfix_mul_arb;
   localparam int N  = 4;
   localparam int NS = 3;

   logic                ap_clk = 1'b0;
   logic                ap_rst_n;
   logic [N-1:0]        req_valid;
   logic [N-1:0]        req_ready;
   logic [17*N-1:0]     req_a;
   logic [17*N-1:0]     req_b;
   logic                rsp_valid;
   logic                rsp_ready;
   logic signed [33:0]  rsp_p;
   logic [1:0]          rsp_id;

   always #5 ap_clk = ~ap_clk;

   distfix_mul_arb dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_p     (rsp_p),
      .rsp_id    (rsp_id)
   );

   typedef struct {
      int     id;
      int     a;
      int     b;
      longint p;
   } vec_t;

   typedef struct {
      int     id;
      longint p;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 1'b0;
   exp_t sb [$];
   int   opa [N];
   int   opb [N];
   vec_t vecs [7];

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int opnd(input logic [17*N-1:0] bus, input int i);
      logic signed [16:0] t;
      t = bus[i*17 +: 17];
      return int'(t);
   endfunction

   task automatic cyc();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic do_reset();
      ap_rst_n = 1'b0;
      cyc();
      ap_rst_n = 1'b1;
   endtask

   task automatic load_ops();
      for (int i = 0; i < N; i++) begin
         req_a[i*17 +: 17] = 17'(opa[i]);
         req_b[i*17 +: 17] = 17'(opb[i]);
      end
   endtask

   // Scoreboard: transfers enqueue expected products, pops must match in issue order.
   always @(negedge ap_clk) begin
      exp_t e;
      if (!ap_rst_n) begin
         sb.delete();
      end else if (mon_en) begin
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("sb_rsp_p", longint'(rsp_p), e.p);
               chk("sb_rsp_id", longint'(rsp_id), longint'(e.id));
            end
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               e.id = i;
               e.p  = longint'(opnd(req_a, i)) * longint'(opnd(req_b, i));
               sb.push_back(e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit got;
      longint prod0;

      ap_rst_n  = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;

      vecs[0] = '{2, -3, 5, -15};
      vecs[1] = '{0, -65536, -65536, 64'sd4294967296};
      vecs[2] = '{1, -65536, 65535, -64'sd4294901760};
      vecs[3] = '{3, 65535, 65535, 64'sd4294836225};
      vecs[4] = '{2, 0, -123, 0};
      vecs[5] = '{1, 1234, -2, -2468};
      vecs[6] = '{0, -1, -1, 1};

      opa = '{-3, 100, -2000, 32767};
      opb = '{7, -9, 31, -32768};
      load_ops();

      // Reset state with every requester asking
      req_valid = '1;
      cyc();
      cyc();
      @(negedge ap_clk);
      chk("reset_req_ready", longint'(req_ready), 0);
      chk("reset_rsp_valid", longint'(rsp_valid), 0);
      cyc();
      ap_rst_n  = 1'b1;
      req_valid = '0;
      mon_en    = 1'b1;

      // Table: single ops, latency and product
      rsp_ready = 1'b1;
      foreach (vecs[v]) begin
         req_a = {4'($urandom), $urandom, $urandom};
         req_b = {4'($urandom), $urandom, $urandom};
         req_a[vecs[v].id*17 +: 17] = 17'(vecs[v].a);
         req_b[vecs[v].id*17 +: 17] = 17'(vecs[v].b);
         req_valid = 4'(1 << vecs[v].id);
         @(negedge ap_clk);
         chk("tbl_grant", longint'(req_ready), longint'(1 << vecs[v].id));
         cyc();
         req_valid = '0;
         req_a = {4'($urandom), $urandom, $urandom};
         req_b = {4'($urandom), $urandom, $urandom};
         lat = 1;
         got = 1'b0;
         while (lat <= 10) begin
            @(negedge ap_clk);
            if (rsp_valid) begin
               got = 1'b1;
               break;
            end
            cyc();
            lat++;
         end
         chk("tbl_rsp_seen", longint'(got), 1);
         chk("tbl_latency", longint'(lat), NS);
         chk("tbl_rsp_p", longint'(rsp_p), vecs[v].p);
         chk("tbl_rsp_id", longint'(rsp_id), longint'(vecs[v].id));
         cyc();
         @(negedge ap_clk);
         chk("tbl_popped", longint'(rsp_valid), 0);
         cyc();
      end

      // Fairness: continuous requests, one grant per cycle in 0,1,2,3 order
      do_reset();
      load_ops();
      rsp_ready = 1'b1;
      req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         @(negedge ap_clk);
         chk("rr_grant", longint'(req_ready), longint'(1 << (k % 4)));
         cyc();
      end
      req_valid = '0;
      repeat (NS + 3) cyc();
      chk("rr_drained", longint'(sb.size()), 0);

      // Backpressure: exactly FIFO_DEPTH transfers, stable head, resume one cycle after first pop
      do_reset();
      rsp_ready = 1'b0;
      req_valid = '1;
      prod0 = longint'(opa[0]) * longint'(opb[0]);
      for (int k = 0; k < 4; k++) begin
         @(negedge ap_clk);
         chk("bp_grant", longint'(req_ready), longint'(1 << k));
         cyc();
      end
      for (int k = 4; k < 8; k++) begin
         @(negedge ap_clk);
         chk("bp_stall", longint'(req_ready), 0);
         chk("bp_head_valid", longint'(rsp_valid), 1);
         chk("bp_head_p", longint'(rsp_p), prod0);
         chk("bp_head_id", longint'(rsp_id), 0);
         cyc();
      end
      rsp_ready = 1'b1;
      @(negedge ap_clk);
      chk("bp_pop_cycle_ready", longint'(req_ready), 0);
      cyc();
      @(negedge ap_clk);
      chk("bp_resume_grant", longint'(req_ready), 1);
      cyc();
      // Full FIFO with interleaved push/pop; the scoreboard checks ordering
      for (int k = 0; k < 16; k++) begin
         rsp_ready = (k % 3) != 2;
         cyc();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (10) cyc();
      chk("bp_drained", longint'(sb.size()), 0);

      // Reset with three ops outstanding
      do_reset();
      rsp_ready = 1'b0;
      req_valid = '1;
      repeat (3) cyc();
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      chk("mr_ready_in_rst", longint'(req_ready), 0);
      chk("mr_rsp_in_rst", longint'(rsp_valid), 0);
      cyc();
      ap_rst_n  = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge ap_clk);
         chk("mr_no_rsp", longint'(rsp_valid), 0);
         cyc();
      end
      req_valid = '1;
      @(negedge ap_clk);
      chk("mr_first_grant", longint'(req_ready), 1);
      cyc();
      req_valid = '0;
      repeat (NS + 3) cyc();
      chk("mr_drained", longint'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
